segment_pack: RTL

Receive-side companion to the DDC segment generator. Consumes the 4-phase interleaved sample stream, each sample tagged with its 2-bit `segment` phase, and re-assembles every segment 0..3 quartet into one 4-lane word. Words go through a small first-word-fall-through FIFO to the SRIO packetiser. The block realigns on PRI, checks phase continuity, and reports sequence errors and overflow.

---
 rtl/segment_pack.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/segment_pack.sv
// -----------------------------------------------------------------------------
// segment_pack
//
// Receive-side re-assembler for the 4-phase interleaved DDC sample stream.
// Every valid sample carries a 2-bit phase tag. A run of phases 0,1,2,3 is
// packed into one 4-lane word and queued in a small first-word-fall-through
// FIFO for the SRIO packetiser. PRI realigns the assembler. Phase breaks are
// reported as sequence errors. Words that arrive while the FIFO is full are
// dropped and flagged as overflow.
//
// Parameters
//   DW        sample width per lane
//   DEPTH     output FIFO depth in words (power of two, >= 2)
//
// Ports
//   clk       system clock
//   rst_n     synchronous, active-low reset
//   PRI       pulse-repetition-interval strobe; restarts assembly
//   segment   phase tag of din (0..3)
//   din       sample
//   din_vld   din/segment valid
//   dout      packed word; [DW-1:0] = phase 0 ... [4*DW-1:3*DW] = phase 3
//   dout_vld  FIFO non-empty, dout valid
//   dout_rdy  consumer accepts dout this cycle
//   dout_sop  dout is the first word after PRI or reset
//   seg_err   one-cycle pulse on a phase-sequence error
//   err_cnt   saturating count of seg_err events
//   ovf       sticky: a completed word was dropped on a full FIFO
// -----------------------------------------------------------------------------
module segment_pack #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PRI,
  input  logic [1:0]      segment,
  input  logic [DW-1:0]   din,
  input  logic            din_vld,
  output logic [4*DW-1:0] dout,
  output logic            dout_vld,
  input  logic            dout_rdy,
  output logic            dout_sop,
  output logic            seg_err,
  output logic [15:0]     err_cnt,
  output logic            ovf
);

  localparam int AW = $clog2(DEPTH);
  // FIFO entry: {sop tag, packed word}
  localparam int WW = 4*DW + 1;
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  localparam logic ST_WAIT_SYNC = 1'b0;
  localparam logic ST_COLLECT   = 1'b1;

  // ---------------------------------------------------------------------------
  // Assembler state
  // ---------------------------------------------------------------------------
  logic        r_state;
  logic [1:0]  r_exp;
  logic        r_sop_pend;
  logic        r_seg_err;
  logic [15:0] r_err_cnt;

  logic        w_state_next;
  logic [1:0]  w_exp_next;
  logic        w_sop_pend_next;
  logic        w_store;       // current sample goes into lane[segment]
  logic        w_word_done;   // current sample is a matching phase 3
  logic        w_seg_err_next;

  // Phase-3 samples are never held in a lane: they complete the word
  // straight from din, so only lanes 0..2 need storage.
  logic [3*DW-1:0] w_lanes;

  always_comb begin
    w_state_next    = r_state;
    w_exp_next      = r_exp;
    w_sop_pend_next = r_sop_pend;
    w_store         = 1'b0;
    w_word_done     = 1'b0;
    w_seg_err_next  = 1'b0;

    if (PRI) begin
      // PRI wins over any sample in the same cycle, including a completing
      // phase 3; the partial word is abandoned without an error.
      w_state_next    = ST_WAIT_SYNC;
      w_exp_next      = 2'd0;
      w_sop_pend_next = 1'b1;
    end else if (din_vld) begin
      case (r_state)
        ST_WAIT_SYNC: begin
          // Only a phase 0 can start a word; anything else is ignored
          // quietly while hunting for alignment.
          if (segment == 2'd0) begin
            w_store      = 1'b1;
            w_exp_next   = 2'd1;
            w_state_next = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (segment == r_exp) begin
            if (segment == 2'd3) begin
              w_word_done     = 1'b1;
              w_sop_pend_next = 1'b0;
              w_exp_next      = 2'd0;
            end else begin
              w_store    = 1'b1;
              w_exp_next = r_exp + 2'd1;
            end
          end else begin
            w_seg_err_next = 1'b1;
            if (segment == 2'd0) begin
              // An unexpected phase 0 is a usable resync point.
              w_store    = 1'b1;
              w_exp_next = 2'd1;
            end else begin
              w_state_next = ST_WAIT_SYNC;
              w_exp_next   = 2'd0;
            end
          end
        end
        default: begin
          w_state_next = ST_WAIT_SYNC;
          w_exp_next   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_WAIT_SYNC;
      r_exp      <= 2'd0;
      r_sop_pend <= 1'b1;
      r_seg_err  <= 1'b0;
      r_err_cnt  <= 16'd0;
    end else begin
      r_state    <= w_state_next;
      r_exp      <= w_exp_next;
      r_sop_pend <= w_sop_pend_next;
      r_seg_err  <= w_seg_err_next;
      if (w_seg_err_next && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  // Lane registers 0..2, each loaded when a stored sample carries its phase.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [DW-1:0] r_lane;
      logic          w_we;

      assign w_we = w_store && (segment == 2'(gi));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_lane <= '0;
        end else if (w_we) begin
          r_lane <= din;
        end
      end

      assign w_lanes[gi*DW +: DW] = r_lane;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Push stage: the completed word is registered once before it enters the
  // FIFO, so the full/accept decision is made against a stable word.
  // ---------------------------------------------------------------------------
  logic          r_push_vld;
  logic [WW-1:0] r_push_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_push_vld  <= 1'b0;
      r_push_word <= '0;
    end else begin
      r_push_vld <= w_word_done;
      if (w_word_done) begin
        r_push_word <= {r_sop_pend, din, w_lanes};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [WW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic [WW-1:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_FULL);
  assign w_pop   = !w_empty && dout_rdy;
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign w_push_ok = r_push_vld && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= r_push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_push_vld && !w_push_ok) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // The head entry is read through so dout is valid in the same cycle that
  // dout_vld rises; it is masked while empty so dout idles at zero.
  assign w_head   = r_mem[r_rd_ptr];
  assign dout_vld = !w_empty;
  assign dout     = w_empty ? '0 : w_head[4*DW-1:0];
  assign dout_sop = !w_empty && w_head[WW-1];
  assign seg_err  = r_seg_err;
  assign err_cnt  = r_err_cnt;
  assign ovf      = r_ovf;

endmodule
